reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 127 ++++++++++++
 tb/tb_reorder_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer for renamed register writes.
// Entries are allocated at the tail, marked done out of order by the
// execution units, and retired strictly from the head, one per cycle.
// Each retire emits a registered one-cycle pulse carrying old_phys so the
// renamer can return that physical register to its free list.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int PW    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       alloc_valid,
  input  logic [2*PW-1:0]            alloc_wbs,
  output logic                       alloc_ready,
  output logic [$clog2(DEPTH)-1:0]   alloc_tag,
  input  logic                       complete_valid,
  input  logic [$clog2(DEPTH)-1:0]   complete_tag,
  output logic                       retire_ena_out,
  output logic [PW-1:0]              retire_phys_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int TW = $clog2(DEPTH);
  localparam logic [TW-1:0] TAG_ONE  = TW'(1);
  localparam logic [TW:0]   CNT_ONE  = (TW+1)'(1);
  localparam logic [TW:0]   CNT_FULL = (TW+1)'(DEPTH);

  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [DEPTH-1:0]          done_q, done_d;
  logic [DEPTH-1:0][PW-1:0]  old_q, old_d;
  logic [DEPTH-1:0][PW-1:0]  new_q, new_d;
  logic [TW-1:0]             head_q, head_d;
  logic [TW-1:0]             tail_q, tail_d;
  logic [TW:0]               count_q, count_d;
  logic                      ret_ena_q, ret_ena_d;
  logic [PW-1:0]             ret_phys_q, ret_phys_d;

  logic do_alloc;
  logic do_retire;

  // new_phys is kept with each entry for the renamer's benefit but no
  // output of this block consumes it.
  logic unused_new_phys;
  assign unused_new_phys = ^new_q;

  // No same-cycle retire bypass: a full buffer refuses even when the head
  // is about to leave, which keeps alloc_ready a pure function of count.
  assign alloc_ready     = (count_q != CNT_FULL);
  assign alloc_tag       = tail_q;
  assign count           = count_q;
  assign retire_ena_out  = ret_ena_q;
  assign retire_phys_out = ret_phys_q;

  // Next-state: completion first, then retire, then allocate, so a
  // retiring head is cleared even if a completion targets it this edge.
  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    old_d      = old_q;
    new_d      = new_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ret_ena_d  = 1'b0;
    ret_phys_d = '0;
    do_alloc   = 1'b0;
    do_retire  = 1'b0;

    if (ena) begin
      do_retire = valid_q[head_q] && done_q[head_q];
      do_alloc  = alloc_valid && alloc_ready;

      if (complete_valid && valid_q[complete_tag]) begin
        done_d[complete_tag] = 1'b1;
      end

      if (do_retire) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + TAG_ONE;
        ret_ena_d       = 1'b1;
        ret_phys_d      = old_q[head_q];
      end

      if (do_alloc) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        old_d[tail_q]   = alloc_wbs[2*PW-1:PW];
        new_d[tail_q]   = alloc_wbs[PW-1:0];
        tail_d          = tail_q + TAG_ONE;
      end

      if (do_alloc && !do_retire) begin
        count_d = count_q + CNT_ONE;
      end else if (!do_alloc && do_retire) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // State registers; reset drops every entry and any pending retire pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      done_q     <= '0;
      old_q      <= '0;
      new_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ret_ena_q  <= 1'b0;
      ret_phys_q <= '0;
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      old_q      <= old_d;
      new_q      <= new_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ret_ena_q  <= ret_ena_d;
      ret_phys_q <= ret_phys_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (DEPTH=8, PW=4).
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b1;
  logic       alloc_valid = 1'b0;
  logic [7:0] alloc_wbs = '0;
  logic       alloc_ready;
  logic [2:0] alloc_tag;
  logic       complete_valid = 1'b0;
  logic [2:0] complete_tag = '0;
  logic       retire_ena_out;
  logic [3:0] retire_phys_out;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  reorder_buffer #(.DEPTH(8), .PW(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .ena             (ena),
    .alloc_valid     (alloc_valid),
    .alloc_wbs       (alloc_wbs),
    .alloc_ready     (alloc_ready),
    .alloc_tag       (alloc_tag),
    .complete_valid  (complete_valid),
    .complete_tag    (complete_tag),
    .retire_ena_out  (retire_ena_out),
    .retire_phys_out (retire_phys_out),
    .count           (count)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then settle 1ns before driving/sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ena = 1'b1;
    alloc_valid = 1'b0;
    alloc_wbs = '0;
    complete_valid = 1'b0;
    complete_tag = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b exp 1", alloc_ready); end
    n_checks++; if (alloc_tag !== 3'd0) begin n_fail++; $display("FAIL reset_tag got %0d exp 0", alloc_tag); end
    n_checks++; if (retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL reset_ret_ena got %0b exp 0", retire_ena_out); end
    n_checks++; if (retire_phys_out !== 4'd0) begin n_fail++; $display("FAIL reset_ret_phys got %0d exp 0", retire_phys_out); end
  endtask

  task automatic test_single();
    do_reset();
    alloc_valid = 1'b1;
    alloc_wbs = {4'd3, 4'd8};
    n_checks++; if (alloc_tag !== 3'd0) begin n_fail++; $display("FAIL single_tag got %0d exp 0", alloc_tag); end
    tick();
    alloc_valid = 1'b0;
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count1 got %0d exp 1", count); end
    complete_valid = 1'b1;
    complete_tag = 3'd0;
    tick();
    complete_valid = 1'b0;
    n_checks++; if (retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL single_early_ret got %0b exp 0", retire_ena_out); end
    tick();
    n_checks++; if (retire_ena_out !== 1'b1) begin n_fail++; $display("FAIL single_ret_ena got %0b exp 1", retire_ena_out); end
    n_checks++; if (retire_phys_out !== 4'd3) begin n_fail++; $display("FAIL single_ret_phys got %0d exp 3", retire_phys_out); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL single_count0 got %0d exp 0", count); end
    tick();
    n_checks++; if (retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL single_pulse_len got %0b exp 0", retire_ena_out); end
    n_checks++; if (retire_phys_out !== 4'd0) begin n_fail++; $display("FAIL single_phys_clr got %0d exp 0", retire_phys_out); end
  endtask

  task automatic test_in_order();
    logic [3:0] got [$];
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'd10; exp_seq[1] = 4'd11; exp_seq[2] = 4'd12;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_wbs = {4'(10 + i), 4'(i)};
      n_checks++; if (alloc_tag !== 3'(i)) begin n_fail++; $display("FAIL order_tag got %0d exp %0d", alloc_tag, i); end
      tick();
    end
    alloc_valid = 1'b0;
    complete_valid = 1'b1;
    complete_tag = 3'd2;
    tick();
    complete_tag = 3'd1;
    tick();
    complete_valid = 1'b0;
    tick();
    n_checks++; if (retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL order_held got %0b exp 0", retire_ena_out); end
    n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL order_held_count got %0d exp 3", count); end
    complete_valid = 1'b1;
    complete_tag = 3'd0;
    tick();
    complete_valid = 1'b0;
    n_checks++; if (retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL order_latency got %0b exp 0", retire_ena_out); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (retire_ena_out !== 1'b1) begin n_fail++; $display("FAIL order_consec got %0b exp 1 at cycle %0d", retire_ena_out, c); end
      if (retire_ena_out === 1'b1) got.push_back(retire_phys_out);
      n_checks++; if (count !== 4'(2 - c)) begin n_fail++; $display("FAIL order_count got %0d exp %0d", count, 2 - c); end
    end
    n_checks++; if (got.size() !== 3) begin n_fail++; $display("FAIL order_nret got %0d exp 3", got.size()); end
    for (int k = 0; k < got.size() && k < 3; k++) begin
      n_checks++; if (got[k] !== exp_seq[k]) begin n_fail++; $display("FAIL order_phys[%0d] got %0d exp %0d", k, got[k], exp_seq[k]); end
    end
    tick();
    n_checks++; if (retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL order_tail got %0b exp 0", retire_ena_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_valid = 1'b1;
    alloc_wbs = {4'd1, 4'd0};
    tick();
    alloc_wbs = {4'd2, 4'd0};
    complete_valid = 1'b1;
    complete_tag = 3'd0;
    tick();
    complete_valid = 1'b0;
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL b2b_count2 got %0d exp 2", count); end
    alloc_wbs = {4'd3, 4'd0};
    tick();
    alloc_valid = 1'b0;
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL b2b_same_count got %0d exp 2", count); end
    n_checks++; if (retire_phys_out !== 4'd1 || retire_ena_out !== 1'b1) begin n_fail++; $display("FAIL b2b_retire got ena=%0b phys=%0d exp ena=1 phys=1", retire_ena_out, retire_phys_out); end
    n_checks++; if (alloc_tag !== 3'd3) begin n_fail++; $display("FAIL b2b_tag got %0d exp 3", alloc_tag); end
  endtask

  // fill, overflow attempt, wrap, then full-with-done-head, then drain
  task automatic test_full_wrap();
    logic [3:0] got [$];
    logic [3:0] exp_seq [8];
    exp_seq = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd13};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1;
      alloc_wbs = {4'(i), 4'(i + 8)};
      tick();
    end
    alloc_wbs = {4'd15, 4'd15};
    n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b exp 0", alloc_ready); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d exp 8", count); end
    tick();
    alloc_valid = 1'b0;
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_drop_count got %0d exp 8", count); end
    n_checks++; if (alloc_tag !== 3'd0) begin n_fail++; $display("FAIL full_drop_tag got %0d exp 0", alloc_tag); end
    complete_valid = 1'b1;
    complete_tag = 3'd0;
    tick();
    complete_valid = 1'b0;
    tick();
    n_checks++; if (retire_ena_out !== 1'b1 || retire_phys_out !== 4'd0) begin n_fail++; $display("FAIL wrap_retire got ena=%0b phys=%0d exp ena=1 phys=0", retire_ena_out, retire_phys_out); end
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready got %0b exp 1", alloc_ready); end
    n_checks++; if (alloc_tag !== 3'd0) begin n_fail++; $display("FAIL wrap_tag got %0d exp 0", alloc_tag); end
    alloc_valid = 1'b1;
    alloc_wbs = {4'd9, 4'd1};
    tick();
    alloc_valid = 1'b0;
    n_checks++; if (count !== 4'd8 || alloc_tag !== 3'd1) begin n_fail++; $display("FAIL wrap_alloc got count=%0d tag=%0d exp count=8 tag=1", count, alloc_tag); end

    // full buffer, head done, alloc held: retire on edge N, alloc on N+1
    alloc_valid = 1'b1;
    alloc_wbs = {4'd13, 4'd2};
    complete_valid = 1'b1;
    complete_tag = 3'd1;
    tick();
    complete_valid = 1'b0;
    n_checks++; if (count !== 4'd8 || alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fra_pre got count=%0d ready=%0b exp count=8 ready=0", count, alloc_ready); end
    tick();
    n_checks++; if (retire_ena_out !== 1'b1 || retire_phys_out !== 4'd1) begin n_fail++; $display("FAIL fra_retire got ena=%0b phys=%0d exp ena=1 phys=1", retire_ena_out, retire_phys_out); end
    n_checks++; if (count !== 4'd7 || alloc_tag !== 3'd1) begin n_fail++; $display("FAIL fra_refused got count=%0d tag=%0d exp count=7 tag=1", count, alloc_tag); end
    tick();
    alloc_valid = 1'b0;
    n_checks++; if (count !== 4'd8 || alloc_tag !== 3'd2) begin n_fail++; $display("FAIL fra_accept got count=%0d tag=%0d exp count=8 tag=2", count, alloc_tag); end

    // drain across the wrap; the dropped 9th alloc (old 15) must not appear
    for (int c = 0; c < 16; c++) begin
      complete_valid = (c < 8);
      complete_tag = 3'((2 + c) % 8);
      tick();
      if (retire_ena_out === 1'b1) got.push_back(retire_phys_out);
    end
    complete_valid = 1'b0;
    n_checks++; if (got.size() !== 8) begin n_fail++; $display("FAIL drain_nret got %0d exp 8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      n_checks++; if (got[k] !== exp_seq[k]) begin n_fail++; $display("FAIL drain_phys[%0d] got %0d exp %0d", k, got[k], exp_seq[k]); end
    end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL drain_count got %0d exp 0", count); end
  endtask

  task automatic test_invalid_complete();
    int nret = 0;
    do_reset();
    complete_valid = 1'b1;
    complete_tag = 3'd5;
    tick();
    complete_valid = 1'b0;
    n_checks++; if (count !== 4'd0 || retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL inv_noeffect got count=%0d ena=%0b exp 0 0", count, retire_ena_out); end
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1'b1;
      alloc_wbs = {4'(i + 1), 4'd0};
      tick();
    end
    alloc_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      complete_valid = (c < 5);
      complete_tag = 3'(c);
      tick();
      if (retire_ena_out === 1'b1) nret++;
    end
    complete_valid = 1'b0;
    n_checks++; if (nret !== 5) begin n_fail++; $display("FAIL inv_nret got %0d exp 5", nret); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL inv_entry5_held got count=%0d exp 1", count); end
    complete_valid = 1'b1;
    complete_tag = 3'd5;
    tick();
    complete_valid = 1'b0;
    tick();
    n_checks++; if (retire_ena_out !== 1'b1 || retire_phys_out !== 4'd6) begin n_fail++; $display("FAIL inv_retire5 got ena=%0b phys=%0d exp ena=1 phys=6", retire_ena_out, retire_phys_out); end
  endtask

  task automatic test_ena_and_midreset();
    do_reset();
    alloc_valid = 1'b1;
    alloc_wbs = {4'd7, 4'd0};
    tick();
    alloc_wbs = {4'd8, 4'd0};
    tick();
    ena = 1'b0;
    alloc_wbs = {4'd9, 4'd0};
    complete_valid = 1'b1;
    complete_tag = 3'd0;
    tick();
    tick();
    tick();
    n_checks++; if (count !== 4'd2 || alloc_tag !== 3'd2) begin n_fail++; $display("FAIL ena0_hold got count=%0d tag=%0d exp count=2 tag=2", count, alloc_tag); end
    n_checks++; if (retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL ena0_noretire got %0b exp 0", retire_ena_out); end
    complete_valid = 1'b0;
    ena = 1'b1;
    tick();
    n_checks++; if (retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL ena0_no_done got %0b exp 0", retire_ena_out); end
    alloc_wbs = {4'd10, 4'd0};
    tick();
    alloc_valid = 1'b0;
    n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL mid_count4 got %0d exp 4", count); end
    complete_valid = 1'b1;
    complete_tag = 3'd0;
    tick();
    complete_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (count !== 4'd0 || retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst got count=%0d ena=%0b exp 0 0", count, retire_ena_out); end
    n_checks++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin n_fail++; $display("FAIL mid_rst_alloc got ready=%0b tag=%0d exp 1 0", alloc_ready, alloc_tag); end
    tick();
    n_checks++; if (retire_ena_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pulse got %0b exp 0", retire_ena_out); end
    rst = 1'b1;
    alloc_valid = 1'b1;
    alloc_wbs = {4'd4, 4'd5};
    tick();
    alloc_valid = 1'b0;
    n_checks++; if (count !== 4'd1 || alloc_tag !== 3'd1) begin n_fail++; $display("FAIL post_rst_alloc got count=%0d tag=%0d exp 1 1", count, alloc_tag); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_in_order();
    test_back_to_back();
    test_full_wrap();
    test_invalid_complete();
    test_ena_and_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // hard stop in case something stalls the sequence
  initial begin
    #200000;
    $display("FAIL timeout reached checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
